key_display_mux: RTL
====================

# key_display_mux

Consumes decoded keypad presses from the row/column scanner (4-bit hex `value` plus one-cycle `enable` strobe) and keeps a two-entry key history: newest key on the right digit, previous key on the left. Drives a time-multiplexed, common-anode dual seven-segment display with a blanking interval between digit phases to prevent ghosting. Sits directly downstream of the scanner and is the last stage before the display pins.

## Interface
Parameters:
- `REFRESH`, default 24000: cycles per digit phase (blank plus active); ≈1 kHz frame at 48 MHz. Must satisfy `REFRESH` > `BLANK` ≥ 1.
- `BLANK`, default 64: cycles at the start of each phase with both anodes off.

Ports:
- `clk`, input, 1: single system clock.
- `reset`, input, 1: synchronous, active-low; 0 on a rising `clk` edge resets the block.
- `value`, input, 4: hex code of the pressed key from the scanner; valid whenever `enable` = 1.
- `enable`, input, 1: new-key strobe from the scanner. Nominally one cycle wide; may be held longer.
- `seg`, output, 7: active-low segments, bit order {g,f,e,d,c,b,a}. Registered.
- `an`, output, 2: active-low anode selects. `an[0]` is the right (newest) digit; `an[1]` is the left (previous) digit. Registered.
- `digit_new`, output, 4: newest captured key. Registered; used for debug/LEDs.
- `digit_old`, output, 4: previous captured key. Registered.

## Operation
- Strobe capture:
  - `enable_q` is `enable` registered one cycle; `accept = enable & ~enable_q` (rising-edge detect).
  - On `accept`: `digit_old <= digit_new` and `digit_new <= value`, where `value` is sampled in the same cycle as `accept`.
  - `enable` held high for N cycles produces exactly one capture.
  - Pressing the same key twice gives `digit_new == digit_old`. Both presses shift normally.
- Phase FSM with 4 states, in this order:
  - `RB` (right blank), then `RA` (right active), then `LB` (left blank), then `LA` (left active), then back to `RB`.
  - Phase counter `cnt` has width `$clog2(REFRESH)`. It resets to 0 on every state change and otherwise increments.
  - `RB`/`LB` exit when `cnt == BLANK-1`.
  - `RA`/`LA` exit when `cnt == REFRESH-BLANK-1`.
- Output register, updated every cycle from the current state:
  - `RB`/`LB`: `an = 2'b11`, `seg = 7'h7F`.
  - `RA`: `an = 2'b10`, `seg = dec(digit_new)`.
  - `LA`: `an = 2'b01`, `seg = dec(digit_old)`.
- Decoder `dec` (hex → `seg`):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Reset values (all outputs): `state = RB`, `cnt = 0`, `enable_q = 0`, `digit_new = 0`, `digit_old = 0`, `an = 2'b11`, `seg = 7'h7F`.
- Only one anode is ever low at a time. `an = 2'b00` is illegal.

## Timing
- Reset: `reset` low at edge E clears everything at E. The first edge with `reset` high is frame cycle 0, in `RB`.
- Reset mid-operation:
  - Any pending capture is lost.
  - The display blanks on the same edge.
  - The frame restarts at `RB`.
- Capture latency: `accept` in cycle N → `digit_new`/`digit_old` updated at the end of cycle N, visible in N+1.
- Display latency:
  - `an`/`seg` lag the state by 1 cycle.
  - A capture appears on `seg` at the first `RA`/`LA` cycle after N+1, plus the 1-cycle output lag.
  - A capture during an active phase updates `seg` mid-phase; this is allowed.
- Frame: `RB` for `BLANK` cycles, then `RA` for `REFRESH-BLANK` cycles, then the same for `LB`/`LA`. Total `2*REFRESH` cycles, periodic, never stalls.
- A strobe coincident with a state transition is captured normally. The FSM is unaffected by key activity.
- `enable` high during reset, then still high after release: `enable_q` was 0, so an `accept` fires on the first post-reset cycle.

## Test plan
Benches use `REFRESH=8`, `BLANK=2`.

1. Reset hold then release, no keys → `an` sequence per 16-cycle frame, after 1-cycle lag: 11,11, 10×6, 11,11, 01×6; `seg` = 7'h40 in both active phases.
2. One-cycle strobes with `value=5`, then `value=A` → `digit_new=A`, `digit_old=5`; `RA` shows `seg=7'h08`, `LA` shows `seg=7'h12`.
3. `enable` held high 20 cycles with `value=3`, then `value` changes to 7 while still high → single capture: `digit_new=3`, `digit_old=0`.
4. Three strobes with values 1, 1, F → `digit_new=F`, `digit_old=1`; `RA` shows 7'h0E, `LA` shows 7'h79.
5. Strobe timed at the last cycle of `RA` (`cnt==5`) with `value=9` → captured next cycle; the `LA` phase shows the old `digit_new` shifted into `digit_old`; the following `RA` shows 7'h10. Check `an` is never 2'b00.
6. `reset` asserted mid-`LA` after captures → next edge: `an=11`, `seg=7F`, digits 0; frame restarts at `RB` with correct counts.

Source files
------------

// File: rtl/key_display_mux.sv
// Two-key history (newest right, previous left) driven onto a multiplexed
// common-anode dual seven-segment display with blanking between digit phases.
module key_display_mux #(
  parameter int unsigned REFRESH = 24000,
  parameter int unsigned BLANK   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       enable,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int unsigned CW = $clog2(REFRESH);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK - 1);
  localparam logic [CW-1:0] ACTIVE_END = CW'(REFRESH - BLANK - 1);

  typedef enum logic [1:0] {
    RB = 2'd0,
    RA = 2'd1,
    LB = 2'd2,
    LA = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          enable_q;
  logic          accept_c;
  logic          phase_end_c;

  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A held strobe captures only once.
  assign accept_c = enable & ~enable_q;

  always_comb begin
    phase_end_c = 1'b0;
    case (state)
      RB, LB:  phase_end_c = (cnt == BLANK_END);
      default: phase_end_c = (cnt == ACTIVE_END);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RB;
      cnt       <= '0;
      enable_q  <= 1'b0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
      an        <= 2'b11;
      seg       <= 7'h7F;
    end else begin
      enable_q <= enable;
      if (accept_c) begin
        digit_old <= digit_new;
        digit_new <= value;
      end

      if (phase_end_c) begin
        cnt <= '0;
        case (state)
          RB:      state <= RA;
          RA:      state <= LB;
          LB:      state <= LA;
          default: state <= RB;
        endcase
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Outputs follow the current state, one cycle behind it.
      case (state)
        RA: begin
          an  <= 2'b10;
          seg <= dec(digit_new);
        end
        LA: begin
          an  <= 2'b01;
          seg <= dec(digit_old);
        end
        default: begin
          an  <= 2'b11;
          seg <= 7'h7F;
        end
      endcase
    end
  end

endmodule
